// File: rtl/taxi_axis_pkt_arb_mux.sv
// ----------------------------------------------------------------------------
// taxi_axis_pkt_arb_mux
//
// Packet-granular AXI-Stream multiplexer. Merges S_COUNT source streams onto
// one output stream. A port wins arbitration on the first beat of a packet and
// keeps the grant until its tlast beat is accepted, so packets never
// interleave. The arbiter is either round robin or fixed priority, and the
// LSB_HIGH_PRIO parameter selects which end of the port range wins ties.
// The output side is a two-entry skid buffer (main + temp), so m_* come
// straight from flops.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   s_tdata     S_COUNT*DATA_W  per-port data, port i at [i*DATA_W +: DATA_W]
//   s_tkeep     S_COUNT*KEEP_W  per-port byte enables
//   s_tuser     S_COUNT*USER_W  per-port sideband
//   s_tlast     S_COUNT         per-port end of packet
//   s_tvalid    S_COUNT         per-port valid
//   s_tready    S_COUNT         per-port ready (only the granted port can be high)
//   m_tdata     DATA_W          merged data
//   m_tkeep     KEEP_W          merged byte enables
//   m_tuser     USER_W          merged sideband
//   m_tlast     1               merged end of packet
//   m_tsrc      clog2(S_COUNT)  source port index of the current beat
//   m_tvalid    1               output valid
//   m_tready    1               output ready
// ----------------------------------------------------------------------------
module taxi_axis_pkt_arb_mux #(
    parameter int S_COUNT         = 4,
    parameter int DATA_W          = 64,
    parameter int KEEP_W          = DATA_W / 8,
    parameter int USER_W          = 1,
    parameter int ARB_ROUND_ROBIN = 1,
    parameter int LSB_HIGH_PRIO   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [S_COUNT*DATA_W-1:0]    s_tdata,
    input  logic [S_COUNT*KEEP_W-1:0]    s_tkeep,
    input  logic [S_COUNT*USER_W-1:0]    s_tuser,
    input  logic [S_COUNT-1:0]           s_tlast,
    input  logic [S_COUNT-1:0]           s_tvalid,
    output logic [S_COUNT-1:0]           s_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic [KEEP_W-1:0]            m_tkeep,
    output logic [USER_W-1:0]            m_tuser,
    output logic                         m_tlast,
    output logic [$clog2(S_COUNT)-1:0]   m_tsrc,
    output logic                         m_tvalid,
    input  logic                         m_tready
);

    localparam int IDX_W  = $clog2(S_COUNT);
    localparam int BEAT_W = 1 + USER_W + KEEP_W + DATA_W + IDX_W;

    typedef enum logic {
        ST_IDLE,
        ST_GRANTED
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [IDX_W-1:0]   r_grantIdx;
    logic [IDX_W-1:0]   w_grantIdxNext;
    logic [S_COUNT-1:0] r_mask;
    logic [S_COUNT-1:0] w_maskNext;

    logic [S_COUNT-1:0] w_req;
    logic [S_COUNT-1:0] w_reqMasked;
    logic [S_COUNT-1:0] w_reqSel;
    logic [S_COUNT-1:0] w_grant;
    logic [IDX_W-1:0]   w_winIdx;
    logic               w_grantValid;
    logic               w_bufferFull;
    logic               w_inAccept;
    logic               w_lastAccept;
    logic [BEAT_W-1:0]  w_inBeat;

    logic [BEAT_W-1:0]  r_mainBeat;
    logic [BEAT_W-1:0]  r_tempBeat;
    logic               r_mainValid;
    logic               r_tempValid;

    // Requests are only visible while nobody holds the grant. In round-robin
    // mode the mask holds the ports that come "after" the last winner; if any
    // of those request they are searched first, otherwise the search wraps to
    // the full request vector. The priority encoder direction follows
    // LSB_HIGH_PRIO.
    always_comb begin
        w_grantValid = (r_state == ST_GRANTED);
        w_req        = w_grantValid ? '0 : s_tvalid;
        w_reqMasked  = (ARB_ROUND_ROBIN != 0) ? (w_req & r_mask) : '0;
        w_reqSel     = (w_reqMasked != '0) ? w_reqMasked : w_req;
        w_winIdx     = '0;
        if (LSB_HIGH_PRIO != 0) begin
            for (int i = S_COUNT - 1; i >= 0; i--) begin
                if (w_reqSel[i]) w_winIdx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < S_COUNT; i++) begin
                if (w_reqSel[i]) w_winIdx = IDX_W'(i);
            end
        end
    end

    // Handshake on the granted port. Readiness drops whenever the skid buffer
    // cannot take another beat, which keeps the temp register as pure margin.
    always_comb begin
        w_grant      = w_grantValid ? (S_COUNT'(1) << r_grantIdx) : '0;
        w_bufferFull = r_tempValid | (r_mainValid & ~m_tready);
        s_tready     = w_grant & {S_COUNT{~w_bufferFull}};
        w_inAccept   = w_grantValid & s_tvalid[r_grantIdx] & ~w_bufferFull;
        w_lastAccept = w_inAccept & s_tlast[r_grantIdx];
        w_inBeat     = {s_tlast[r_grantIdx],
                        s_tuser[r_grantIdx*USER_W +: USER_W],
                        s_tkeep[r_grantIdx*KEEP_W +: KEEP_W],
                        s_tdata[r_grantIdx*DATA_W +: DATA_W],
                        r_grantIdx};
    end

    // Grant state machine, next-state half. The grant is taken on any request
    // from idle and released only after the holder's tlast beat is accepted,
    // so a new winner is always picked one cycle after the previous packet
    // ends. The mask is recomputed only when a new grant is issued.
    always_comb begin
        w_stateNext    = r_state;
        w_grantIdxNext = r_grantIdx;
        w_maskNext     = r_mask;
        case (r_state)
            ST_IDLE: begin
                if (w_req != '0) begin
                    w_stateNext    = ST_GRANTED;
                    w_grantIdxNext = w_winIdx;
                    for (int i = 0; i < S_COUNT; i++) begin
                        w_maskNext[i] = (LSB_HIGH_PRIO != 0) ? (IDX_W'(i) > w_winIdx)
                                                             : (IDX_W'(i) < w_winIdx);
                    end
                end
            end
            ST_GRANTED: begin
                if (w_lastAccept) w_stateNext = ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Grant state machine, register half.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grantIdx <= '0;
            r_mask     <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_grantIdx <= w_grantIdxNext;
            r_mask     <= w_maskNext;
        end
    end

    // Skid buffer. Main drives the outputs; when main drains, it refills from
    // temp first so beat order is preserved. A beat accepted while main is
    // stalled parks in temp.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mainBeat  <= '0;
            r_tempBeat  <= '0;
            r_mainValid <= 1'b0;
            r_tempValid <= 1'b0;
        end else begin
            if (!r_mainValid || m_tready) begin
                if (r_tempValid) begin
                    r_mainBeat  <= r_tempBeat;
                    r_mainValid <= 1'b1;
                    r_tempValid <= 1'b0;
                end else begin
                    r_mainValid <= w_inAccept;
                    if (w_inAccept) r_mainBeat <= w_inBeat;
                end
            end else if (w_inAccept) begin
                r_tempBeat  <= w_inBeat;
                r_tempValid <= 1'b1;
            end
        end
    end

    assign {m_tlast, m_tuser, m_tkeep, m_tdata, m_tsrc} = r_mainBeat;
    assign m_tvalid = r_mainValid;

endmodule

// File: tb/tb_taxi_axis_pkt_arb_mux.sv
// ----------------------------------------------------------------------------
// tb_taxi_axis_pkt_arb_mux
//
// Self-checking bench for taxi_axis_pkt_arb_mux in round-robin mode with the
// lowest index winning ties. A table of per-cycle records (inputs plus
// hand-computed outputs) walks through reset, a single-port packet, a full
// round-robin rotation, output backpressure, a mid-packet input gap and a
// reset in the middle of a packet. A hand-written scoreboard sequence then
// streams a packet under an irregular m_tready pattern.
// Port p drives tdata = {p, dat}, tkeep = 8'hF0 | p and tuser = p[0].
// ----------------------------------------------------------------------------
module tb_taxi_axis_pkt_arb_mux;

    localparam int S_COUNT = 4;
    localparam int DATA_W  = 64;
    localparam int KEEP_W  = 8;
    localparam int USER_W  = 1;

    logic                      clk;
    logic                      rst;
    logic [S_COUNT*DATA_W-1:0] s_tdata;
    logic [S_COUNT*KEEP_W-1:0] s_tkeep;
    logic [S_COUNT*USER_W-1:0] s_tuser;
    logic [S_COUNT-1:0]        s_tlast;
    logic [S_COUNT-1:0]        s_tvalid;
    logic [S_COUNT-1:0]        s_tready;
    logic [DATA_W-1:0]         m_tdata;
    logic [KEEP_W-1:0]         m_tkeep;
    logic [USER_W-1:0]         m_tuser;
    logic                      m_tlast;
    logic [1:0]                m_tsrc;
    logic                      m_tvalid;
    logic                      m_tready;

    taxi_axis_pkt_arb_mux #(
        .S_COUNT         (S_COUNT),
        .DATA_W          (DATA_W),
        .KEEP_W          (KEEP_W),
        .USER_W          (USER_W),
        .ARB_ROUND_ROBIN (1),
        .LSB_HIGH_PRIO   (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tuser  (s_tuser),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tuser  (m_tuser),
        .m_tlast  (m_tlast),
        .m_tsrc   (m_tsrc),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [7:0]  dat;
        logic        mready;
        logic        expValid;
        logic        pay;
        logic [15:0] expData;
        logic        expLast;
        logic [1:0]  expSrc;
        logic [3:0]  expReady;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic logic [7:0] keepOf(input int p);
        return 8'hF0 | 8'(p);
    endfunction

    task automatic a(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic [7:0] d, input logic mr, input logic ev,
                     input logic pay, input logic [15:0] ed, input logic el,
                     input logic [1:0] es, input logic [3:0] er);
        vec_t t;
        t.rst = r; t.valid = v; t.last = l; t.dat = d; t.mready = mr;
        t.expValid = ev; t.pay = pay; t.expData = ed; t.expLast = el;
        t.expSrc = es; t.expReady = er;
        vecs.push_back(t);
    endtask

    task automatic driveBus(input logic r, input logic [3:0] v, input logic [3:0] l,
                            input logic [7:0] d, input logic mr);
        rst      = r;
        s_tvalid = v;
        s_tlast  = l;
        m_tready = mr;
        for (int p = 0; p < S_COUNT; p++) begin
            s_tdata[p*DATA_W +: DATA_W] = {48'h0, 8'(p), d};
            s_tkeep[p*KEEP_W +: KEEP_W] = keepOf(p);
            s_tuser[p]                  = 1'(p & 1);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        driveBus(v.rst, v.valid, v.last, v.dat, v.mready);
    endtask

    task automatic checkBits(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkBits($sformatf("v%0d m_tvalid", idx), 64'(m_tvalid), 64'(v.expValid));
        checkBits($sformatf("v%0d s_tready", idx), 64'(s_tready), 64'(v.expReady));
        if (v.pay) begin
            checkBits($sformatf("v%0d m_tdata", idx), m_tdata, {48'h0, v.expData});
            checkBits($sformatf("v%0d m_tlast", idx), 64'(m_tlast), 64'(v.expLast));
            checkBits($sformatf("v%0d m_tsrc", idx), 64'(m_tsrc), 64'(v.expSrc));
        end
        if (v.expValid) begin
            checkBits($sformatf("v%0d m_tkeep", idx), 64'(m_tkeep), 64'(keepOf(int'(v.expSrc))));
            checkBits($sformatf("v%0d m_tuser", idx), 64'(m_tuser), 64'(v.expSrc[0]));
        end
    endtask

    // Hard stop in case something upstream never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] expQ[$];
        int          sent;
        int          recv;

        driveBus(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1);

        // Reset then idle
        a(1, 4'b0000, 4'b0000, 8'h00, 1, 0, 1, 16'h0000, 0, 0, 4'b0000);
        a(1, 4'b0000, 4'b0000, 8'h00, 1, 0, 1, 16'h0000, 0, 0, 4'b0000);
        a(1, 4'b0000, 4'b0000, 8'h00, 1, 0, 1, 16'h0000, 0, 0, 4'b0000);
        a(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 1, 16'h0000, 0, 0, 4'b0000);
        // Single 4-beat packet from port 2
        a(0, 4'b0100, 4'b0000, 8'h10, 1, 0, 0, 16'h0000, 0, 0, 4'b0000);
        a(0, 4'b0100, 4'b0000, 8'h10, 1, 0, 0, 16'h0000, 0, 0, 4'b0100);
        a(0, 4'b0100, 4'b0000, 8'h11, 1, 1, 1, 16'h0210, 0, 2, 4'b0100);
        a(0, 4'b0100, 4'b0000, 8'h12, 1, 1, 1, 16'h0211, 0, 2, 4'b0100);
        a(0, 4'b0100, 4'b0100, 8'h13, 1, 1, 1, 16'h0212, 0, 2, 4'b0100);
        a(0, 4'b0000, 4'b0000, 8'h00, 1, 1, 1, 16'h0213, 1, 2, 4'b0000);
        a(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'b0000);
        // Clean mask, then all ports offer 2-beat packets: order 0,1,2,3,0,1
        a(1, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'b0000);
        a(0, 4'b1111, 4'b0000, 8'h20, 1, 0, 0, 16'h0000, 0, 0, 4'b0000);
        a(0, 4'b1111, 4'b0000, 8'h20, 1, 0, 0, 16'h0000, 0, 0, 4'b0001);
        a(0, 4'b1111, 4'b0001, 8'h21, 1, 1, 1, 16'h0020, 0, 0, 4'b0001);
        a(0, 4'b1111, 4'b0000, 8'h22, 1, 1, 1, 16'h0021, 1, 0, 4'b0000);
        a(0, 4'b1111, 4'b0000, 8'h22, 1, 0, 0, 16'h0000, 0, 0, 4'b0010);
        a(0, 4'b1111, 4'b0010, 8'h23, 1, 1, 1, 16'h0122, 0, 1, 4'b0010);
        a(0, 4'b1111, 4'b0000, 8'h24, 1, 1, 1, 16'h0123, 1, 1, 4'b0000);
        a(0, 4'b1111, 4'b0000, 8'h24, 1, 0, 0, 16'h0000, 0, 0, 4'b0100);
        a(0, 4'b1111, 4'b0100, 8'h25, 1, 1, 1, 16'h0224, 0, 2, 4'b0100);
        a(0, 4'b1111, 4'b0000, 8'h26, 1, 1, 1, 16'h0225, 1, 2, 4'b0000);
        a(0, 4'b1111, 4'b0000, 8'h26, 1, 0, 0, 16'h0000, 0, 0, 4'b1000);
        a(0, 4'b1111, 4'b1000, 8'h27, 1, 1, 1, 16'h0326, 0, 3, 4'b1000);
        a(0, 4'b1111, 4'b0000, 8'h28, 1, 1, 1, 16'h0327, 1, 3, 4'b0000);
        a(0, 4'b1111, 4'b0000, 8'h28, 1, 0, 0, 16'h0000, 0, 0, 4'b0001);
        a(0, 4'b1111, 4'b0001, 8'h29, 1, 1, 1, 16'h0028, 0, 0, 4'b0001);
        a(0, 4'b1111, 4'b0000, 8'h2A, 1, 1, 1, 16'h0029, 1, 0, 4'b0000);
        a(0, 4'b1111, 4'b0000, 8'h2A, 1, 0, 0, 16'h0000, 0, 0, 4'b0010);
        a(0, 4'b1111, 4'b0010, 8'h2B, 1, 1, 1, 16'h012A, 0, 1, 4'b0010);
        a(0, 4'b0000, 4'b0000, 8'h00, 1, 1, 1, 16'h012B, 1, 1, 4'b0000);
        a(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'b0000);
        // Backpressure: 6-beat packet from port 1, m_tready 1,0,0,1
        a(0, 4'b0010, 4'b0000, 8'h30, 1, 0, 0, 16'h0000, 0, 0, 4'b0000);
        a(0, 4'b0010, 4'b0000, 8'h30, 1, 0, 0, 16'h0000, 0, 0, 4'b0010);
        a(0, 4'b0010, 4'b0000, 8'h31, 0, 1, 1, 16'h0130, 0, 1, 4'b0000);
        a(0, 4'b0010, 4'b0000, 8'h31, 0, 1, 1, 16'h0130, 0, 1, 4'b0000);
        a(0, 4'b0010, 4'b0000, 8'h31, 1, 1, 1, 16'h0130, 0, 1, 4'b0010);
        a(0, 4'b0010, 4'b0000, 8'h32, 1, 1, 1, 16'h0131, 0, 1, 4'b0010);
        a(0, 4'b0010, 4'b0000, 8'h33, 0, 1, 1, 16'h0132, 0, 1, 4'b0000);
        a(0, 4'b0010, 4'b0000, 8'h33, 0, 1, 1, 16'h0132, 0, 1, 4'b0000);
        a(0, 4'b0010, 4'b0000, 8'h33, 1, 1, 1, 16'h0132, 0, 1, 4'b0010);
        a(0, 4'b0010, 4'b0000, 8'h34, 1, 1, 1, 16'h0133, 0, 1, 4'b0010);
        a(0, 4'b0010, 4'b0010, 8'h35, 1, 1, 1, 16'h0134, 0, 1, 4'b0010);
        a(0, 4'b0000, 4'b0000, 8'h00, 1, 1, 1, 16'h0135, 1, 1, 4'b0000);
        a(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'b0000);
        // Port 3 gaps 5 cycles mid-packet while port 0 requests
        a(0, 4'b1000, 4'b0000, 8'h40, 1, 0, 0, 16'h0000, 0, 0, 4'b0000);
        a(0, 4'b1000, 4'b0000, 8'h40, 1, 0, 0, 16'h0000, 0, 0, 4'b1000);
        a(0, 4'b1001, 4'b0000, 8'h41, 1, 1, 1, 16'h0340, 0, 3, 4'b1000);
        a(0, 4'b0001, 4'b0000, 8'h41, 1, 1, 1, 16'h0341, 0, 3, 4'b1000);
        a(0, 4'b0001, 4'b0000, 8'h41, 1, 0, 0, 16'h0000, 0, 0, 4'b1000);
        a(0, 4'b0001, 4'b0000, 8'h41, 1, 0, 0, 16'h0000, 0, 0, 4'b1000);
        a(0, 4'b0001, 4'b0000, 8'h41, 1, 0, 0, 16'h0000, 0, 0, 4'b1000);
        a(0, 4'b0001, 4'b0000, 8'h41, 1, 0, 0, 16'h0000, 0, 0, 4'b1000);
        a(0, 4'b1001, 4'b1000, 8'h42, 1, 0, 0, 16'h0000, 0, 0, 4'b1000);
        a(0, 4'b0001, 4'b0000, 8'h50, 1, 1, 1, 16'h0342, 1, 3, 4'b0000);
        a(0, 4'b0001, 4'b0001, 8'h50, 1, 0, 0, 16'h0000, 0, 0, 4'b0001);
        a(0, 4'b0000, 4'b0000, 8'h00, 1, 1, 1, 16'h0050, 1, 0, 4'b0000);
        // Reset at beat 3 of an 8-beat packet from port 2, then clean re-arbitration
        a(0, 4'b0100, 4'b0000, 8'h60, 1, 0, 0, 16'h0000, 0, 0, 4'b0000);
        a(0, 4'b0100, 4'b0000, 8'h60, 1, 0, 0, 16'h0000, 0, 0, 4'b0100);
        a(0, 4'b0100, 4'b0000, 8'h61, 1, 1, 1, 16'h0260, 0, 2, 4'b0100);
        a(0, 4'b0100, 4'b0000, 8'h62, 1, 1, 1, 16'h0261, 0, 2, 4'b0100);
        a(1, 4'b0100, 4'b0000, 8'h63, 1, 1, 1, 16'h0262, 0, 2, 4'b0100);
        a(0, 4'b1001, 4'b0000, 8'h70, 1, 0, 0, 16'h0000, 0, 0, 4'b0000);
        a(0, 4'b1001, 4'b0001, 8'h70, 1, 0, 0, 16'h0000, 0, 0, 4'b0001);
        a(0, 4'b0000, 4'b0000, 8'h00, 1, 1, 1, 16'h0070, 1, 0, 4'b0000);
        a(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'b0000);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], i);
        end

        // Scoreboard sequence: 3-beat packet from port 1 with irregular m_tready
        for (int k = 0; k < 3; k++) expQ.push_back(16'h0180 + 16'(k));
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 3; cyc++) begin
            @(posedge clk);
            #1;
            driveBus(1'b0, (sent < 3) ? 4'b0010 : 4'b0000, (sent == 2) ? 4'b0010 : 4'b0000,
                     8'(8'h80 + sent), (cyc % 3) != 1);
            @(negedge clk);
            if (s_tvalid[1] && s_tready[1]) sent++;
            if (m_tvalid && m_tready) begin
                checkBits($sformatf("stream beat%0d data", recv), m_tdata, {48'h0, expQ[0]});
                checkBits($sformatf("stream beat%0d last", recv), 64'(m_tlast), 64'(recv == 2));
                checkBits($sformatf("stream beat%0d src", recv), 64'(m_tsrc), 64'd1);
                void'(expQ.pop_front());
                recv++;
            end
        end
        checks++;
        if (recv != 3) begin
            fails++;
            $display("[TB] FAIL stream beat count: got %0d beats, expected 3 within 40 cycles", recv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/taxi_axis_pkt_arb_mux.md
Name: taxi_axis_pkt_arb_mux

Overview:
- Packet-granular AXI-Stream multiplexer. Merges S_COUNT source streams onto one output stream.
- Uses a blocking round-robin or priority arbiter, with arbitration index logic and a grant register.
- A grant is held from the first beat of a packet until its tlast beat is accepted, so packets never interleave.
- Sits directly downstream of per-port MAC/PHY RX FIFOs and feeds the shared packet pipeline.

Parameters:
- S_COUNT, 4, number of input ports (>=2).
- DATA_W, 64, tdata width.
- KEEP_W, DATA_W/8, tkeep width.
- USER_W, 1, tuser width.
- ARB_ROUND_ROBIN, 1, 1 = round robin, 0 = fixed priority.
- LSB_HIGH_PRIO, 0, 1 = lowest index wins ties/fixed priority, 0 = highest index wins.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_tdata  in  S_COUNT*DATA_W  port i occupies slice [i*DATA_W +: DATA_W]
- s_tkeep  in  S_COUNT*KEEP_W  per-port byte enables
- s_tuser  in  S_COUNT*USER_W  per-port sideband
- s_tlast  in  S_COUNT  per-port end of packet
- s_tvalid  in  S_COUNT  per-port valid
- s_tready  out  S_COUNT  per-port ready
- m_tdata  out  DATA_W  merged data
- m_tkeep  out  KEEP_W  merged keep
- m_tuser  out  USER_W  merged user
- m_tlast  out  1  merged last
- m_tsrc  out  $clog2(S_COUNT)  source port index of the current beat
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready

Behaviour:
- Reset (rst, synchronous, active-high; clock clk): grant_valid=0, grant=0, round-robin mask=0, skid buffer emptied; m_tvalid=0, all s_tready=0. m_tdata/m_tkeep/m_tuser/m_tlast/m_tsrc reset to 0.
- Arbitration request vector: req[i] = s_tvalid[i] when no grant is held; 0 otherwise.
- Winner selection:
  - Fixed priority: highest-priority requester per LSB_HIGH_PRIO.
  - Round robin, LSB_HIGH_PRIO=1: after granting port k, ports >k are searched first (ascending), then wrap to lowest index.
  - Round robin, LSB_HIGH_PRIO=0: mirror image (ports <k searched first, descending, then wrap).
- Grant latency: a request visible in cycle N registers the grant in cycle N+1. s_tready[k] may assert from N+1.
- Grant state machine:
  - IDLE -> GRANTED(k) on any req.
  - GRANTED(k) -> IDLE in the cycle after a beat with s_tvalid[k] & s_tready[k] & s_tlast[k].
  - No other transition except reset.
- Grant holding: the grant stays on k while s_tvalid[k] is low mid-packet. Bubbles are passed through as gaps; no re-arbitration.
- Inter-packet gap: minimum one idle cycle at the mux input between back-to-back packets, including the same port twice.
- Readiness: s_tready[i] = grant[i] & ~buffer_full. Ungranted ports always see s_tready=0.
- Output path: 2-entry skid buffer (main + temp register).
  - m_* driven from the main register only; no combinational path from s_* or m_tready to m_*.
  - buffer_full means temp occupied, or main occupied and m_tready=0.
  - Data order preserved; a full-throughput stream (s_tvalid=1, m_tready=1) moves 1 beat/cycle with 1-cycle data latency.
- m_tsrc carries the granted index, captured with each beat.
- m_tvalid/m_* remain stable while m_tvalid=1 and m_tready=0.
- Simultaneous events: tlast acceptance and a new request from another port in the same cycle produce a new grant in the next cycle, not the same cycle.
- Single-beat packets (tlast on first beat) are valid and release the grant immediately.
- Reset mid-packet: grant dropped, buffered beats discarded, m_tvalid=0 the next cycle. A partial packet is not completed.
- Protocol violation (s_tvalid[k] deasserting with tready low) is not checked; data follows the input.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, all s_tvalid=0 -> m_tvalid=0, s_tready=0000, m_tsrc=0 throughout.
- Single port: port 2 sends a 4-beat packet (data 0x10..0x13), m_tready=1.
  - s_tready[2] rises 1 cycle after s_tvalid.
  - m_tdata 0x10..0x13 on consecutive cycles, m_tsrc=2, m_tlast on 0x13 only.
- Round robin, LSB_HIGH_PRIO=1: all 4 ports continuously offer 2-beat packets.
  - Output source order is 0,1,2,3,0,1.
  - Exactly one idle input cycle between packets; no interleaving of beats.
- Backpressure: m_tready toggles 1,0,0,1 during a 6-beat packet from port 1.
  - All 6 beats appear in order with no loss or duplication.
  - m_* held stable while stalled; s_tready[1] low while the buffer is full.
- Mid-packet gap: port 3 deasserts s_tvalid for 5 cycles mid-packet while port 0 requests -> port 0 receives no grant until port 3's tlast is accepted.
- Reset mid-packet: assert rst at beat 3 of an 8-beat packet -> m_tvalid=0 and s_tready=0 the next cycle; after release, a fresh request arbitrates from a clean mask.
